// File: rtl/usb_rx_bank_ctrl.sv
// usb_rx_bank_ctrl: ping-pong receive buffer banks between the USB receiver and the core
module usb_rx_bank_ctrl #(
    parameter int BANK_WORDS = 128,
    parameter int DROP_W     = 8
) (
    input  logic                          clock48,
    input  logic                          reset,
    input  logic                          rx_start,
    input  logic                          rx_word_valid,
    input  logic [31:0]                   rx_word,
    input  logic                          rx_eop,
    input  logic                          rx_error,
    output logic                          rx_accept,
    output logic                          mem_we,
    output logic [$clog2(BANK_WORDS):0]   mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic                          irq,
    output logic                          cpu_bank,
    output logic [$clog2(BANK_WORDS):0]   cpu_length,
    input  logic                          cpu_ack,
    output logic [DROP_W-1:0]             drop_count
);
    localparam int AW = $clog2(BANK_WORDS);
    localparam int IW = AW + 1;
    typedef enum logic [1:0] {W_IDLE, W_RECV, W_DISCARD} wstate_t;
    wstate_t           state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [1:0]        count_q, count_d;
    logic [IW-1:0]     len_q [2];
    logic [IW-1:0]     len_d [2];
    logic [DROP_W-1:0] drop_count_q, drop_count_d;
    logic              irq_q, irq_d;
    logic              mem_we_q, mem_we_d;
    logic [IW-1:0]     mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              commit, drop_inc, ack_eff;
    assign rx_accept  = count_q != 2'd2;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign irq        = irq_q;
    assign cpu_bank   = rd_bank_q;
    assign cpu_length = len_q[rd_bank_q];
    assign drop_count = drop_count_q;
    // writer FSM, bank queue bookkeeping and registered memory write port
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        commit      = 1'b0;
        drop_inc    = 1'b0;
        case (state_q)
            W_IDLE: begin
                if (rx_start) begin
                    state_d  = rx_accept ? W_RECV : W_DISCARD;
                    idx_d    = '0;
                    drop_inc = !rx_accept;
                end
            end
            W_RECV: begin
                if (rx_error) begin
                    state_d = W_IDLE;
                end else if (rx_start) begin
                    idx_d = '0;
                end else if (rx_word_valid && idx_q == IW'(BANK_WORDS)) begin
                    drop_inc = 1'b1;
                    state_d  = rx_eop ? W_IDLE : W_DISCARD;
                end else begin
                    if (rx_word_valid) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {wr_bank_q, idx_q[AW-1:0]};
                        mem_wdata_d = rx_word;
                        idx_d       = idx_q + 1'b1;
                    end
                    if (rx_eop) begin
                        commit  = 1'b1;
                        state_d = W_IDLE;
                    end
                end
            end
            W_DISCARD: begin
                if (rx_error) begin
                    state_d = W_IDLE;
                end else if (rx_start) begin
                    state_d  = rx_accept ? W_RECV : W_DISCARD;
                    idx_d    = '0;
                    drop_inc = !rx_accept;
                end else if (rx_eop) begin
                    state_d = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
        if (commit) len_d[wr_bank_q] = idx_d;
        ack_eff      = cpu_ack && count_q != 2'd0;
        wr_bank_d    = wr_bank_q ^ commit;
        rd_bank_d    = rd_bank_q ^ ack_eff;
        count_d      = count_q + {1'b0, commit} - {1'b0, ack_eff};
        drop_count_d = (drop_inc && !(&drop_count_q)) ? drop_count_q + 1'b1 : drop_count_q;
        irq_d        = count_q != 2'd0;
    end
    // state registers, all cleared asynchronously
    always_ff @(posedge clock48 or posedge reset) begin
        if (reset) begin
            state_q      <= W_IDLE;
            idx_q        <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            count_q      <= '0;
            len_q        <= '{default: '0};
            drop_count_q <= '0;
            irq_q        <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            count_q      <= count_d;
            len_q        <= len_d;
            drop_count_q <= drop_count_d;
            irq_q        <= irq_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end
endmodule

// File: tb/tb_usb_rx_bank_ctrl.sv
// tb_usb_rx_bank_ctrl: directed and random stimulus against a packet-level reference model
module tb_usb_rx_bank_ctrl;
    localparam int BW   = 8;
    localparam int DW   = 4;
    localparam int IW   = $clog2(BW) + 1;
    localparam int DMAX = (1 << DW) - 1;
    logic          clock48 = 1'b0;
    logic          reset = 1'b1;
    logic          rx_start = 1'b0, rx_word_valid = 1'b0, rx_eop = 1'b0, rx_error = 1'b0, cpu_ack = 1'b0;
    logic [31:0]   rx_word = '0;
    logic          rx_accept, mem_we, irq, cpu_bank;
    logic [IW-1:0] mem_addr, cpu_length;
    logic [31:0]   mem_wdata;
    logic [DW-1:0] drop_count;
    int n_cmp = 0, n_bad = 0;
    int mode, n, rd, drops;
    int pend[$];
    int blen[2];
    bit exp_we, exp_irq;
    int exp_addr;
    logic [31:0] exp_data;

    usb_rx_bank_ctrl #(.BANK_WORDS(BW), .DROP_W(DW)) dut (
        .clock48(clock48), .reset(reset), .rx_start(rx_start), .rx_word_valid(rx_word_valid),
        .rx_word(rx_word), .rx_eop(rx_eop), .rx_error(rx_error), .rx_accept(rx_accept),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .irq(irq),
        .cpu_bank(cpu_bank), .cpu_length(cpu_length), .cpu_ack(cpu_ack), .drop_count(drop_count)
    );

    always #5 clock48 = ~clock48;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_start(input int sz);
        if (sz < 2) begin
            mode = 1;
            n = 0;
        end else begin
            mode = 2;
            if (drops < DMAX) drops++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        {rx_start, rx_word_valid, rx_eop, rx_error, cpu_ack} = '0;
        #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_irq", irq, 0);
        chk("rst_cpu_bank", cpu_bank, 0);
        chk("rst_cpu_length", cpu_length, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_accept", rx_accept, 1);
        mode = 0; n = 0; rd = 0; drops = 0; exp_we = 0; exp_irq = 0;
        pend.delete();
        blen = '{0, 0};
        @(posedge clock48);
        #1 reset = 1'b0;
    endtask

    task automatic cyc(input bit s, input bit wv, input bit e, input bit er, input bit ak);
        int sz, wr, cl;
        bit cm;
        logic [31:0] d;
        d = $urandom;
        rx_start = s; rx_word_valid = wv; rx_eop = e; rx_error = er; cpu_ack = ak; rx_word = d;
        #1 chk("rx_accept", rx_accept, pend.size() < 2);
        sz = pend.size();
        wr = (rd + sz) % 2;
        cm = 0; cl = 0; exp_we = 0;
        if (mode == 0) begin
            if (s) m_start(sz);
        end else if (mode == 1) begin
            if (er) mode = 0;
            else if (s) n = 0;
            else if (wv && n == BW) begin
                if (drops < DMAX) drops++;
                mode = e ? 0 : 2;
            end else begin
                if (wv) begin
                    exp_we = 1; exp_addr = wr * BW + n; exp_data = d;
                    n++;
                end
                if (e) begin
                    cm = 1; cl = n; mode = 0;
                end
            end
        end else begin
            if (er) mode = 0;
            else if (s) m_start(sz);
            else if (e) mode = 0;
        end
        if (ak && sz > 0) begin
            void'(pend.pop_front());
            rd ^= 1;
        end
        if (cm) begin
            pend.push_back(cl);
            blen[wr] = cl;
        end
        exp_irq = sz != 0;
        @(posedge clock48);
        #1;
        chk("mem_we", mem_we, exp_we);
        if (exp_we) begin
            chk("mem_addr", mem_addr, exp_addr);
            chk("mem_wdata", mem_wdata, exp_data);
        end
        chk("irq", irq, exp_irq);
        chk("cpu_bank", cpu_bank, rd);
        chk("cpu_length", cpu_length, pend.size() != 0 ? pend[0] : blen[rd]);
        chk("drop_count", drop_count, drops);
    endtask

    initial begin
        do_reset();
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 1, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t1_irq", irq, 1);
        chk("t1_bank", cpu_bank, 0);
        chk("t1_len", cpu_length, 3);

        do_reset();
        repeat (2) begin
            cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 1, 0, 0);
        end
        chk("t2_accept", rx_accept, 0);
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("t2_drop", drop_count, 1);
        chk("t2_len0", cpu_length, 2);
        cyc(0, 0, 0, 0, 1);
        chk("t2_len1", cpu_length, 2);

        do_reset();
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 1, 0, 0);
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 1, 1, 0, 1); cyc(0, 0, 0, 0, 0);
        chk("t3_bank", cpu_bank, 1);
        chk("t3_irq", irq, 1);
        chk("t3_len", cpu_length, 2);

        do_reset();
        cyc(1, 0, 0, 0, 0);
        repeat (BW + 1) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("t4_irq", irq, 0);
        chk("t4_drop", drop_count, 1);

        do_reset();
        cyc(1, 0, 0, 0, 0);
        repeat (5) cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("t5_len", cpu_length, 1);
        chk("t5_drop", drop_count, 0);

        cyc(1, 0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0, 0);
        #2 do_reset();
        cyc(1, 0, 0, 0, 0); cyc(0, 1, 1, 0, 0); cyc(0, 0, 0, 0, 0);
        chk("t6_len", cpu_length, 1);
        chk("t6_bank", cpu_bank, 0);

        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 999) do_reset();
            cyc($urandom_range(0, 99) < 6, $urandom_range(0, 99) < 55, $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 8);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
